// File: rtl/egress_queue.sv
// egress_queue
//
// Output stage placed directly after the arbitrated FIFOs. Every cycle in
// which the arbiter grants exactly one source, the granted word and the
// index of that source are written into a small circular buffer. The buffer
// head is presented on a valid/ready interface, and a registered blk signal
// throttles the arbiter before the buffer can overflow.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous reset, active low
//   gnt      - one-hot grant from the arbiter (nonzero => data_in valid)
//   data_in  - arbiter data word, sampled only on a one-hot grant
//   out_rdy  - downstream ready
//   out_vld  - head entry is valid
//   out_data - head entry data
//   out_src  - head entry source index (bit position of the writing grant)
//   count    - current occupancy
//   blk      - registered back-pressure to the arbiter
//   ovf      - sticky: a grant was dropped because the buffer was full
//   err      - sticky: a multi-hot grant was seen

module egress_queue #(
  parameter int NUM_REQS   = 2,
  parameter int WIDTH      = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int BLK_MARGIN = 2,
  parameter int SIDW       = ($clog2(NUM_REQS) > 0 ? $clog2(NUM_REQS) : 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQS-1:0]            gnt,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           out_rdy,
  output logic                           out_vld,
  output logic [WIDTH-1:0]               out_data,
  output logic [SIDW-1:0]                out_src,
  output logic [$clog2(OUT_DEPTH):0]     count,
  output logic                           blk,
  output logic                           ovf,
  output logic                           err
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [CW-1:0] FULL_LEVEL  = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] BLK_LEVEL   = CW'(OUT_DEPTH - BLK_MARGIN);
  localparam logic [NUM_REQS-1:0] GNT_ONE = NUM_REQS'(1);

  logic [WIDTH-1:0] mem_data [OUT_DEPTH];
  logic [SIDW-1:0]  mem_src  [OUT_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic            gnt_any;
  logic            gnt_one_hot;
  logic            gnt_multi;
  logic [SIDW-1:0] gnt_idx;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [CW-1:0]   count_next;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign gnt_any     = (gnt != '0);
  assign gnt_one_hot = gnt_any && ((gnt & (gnt - GNT_ONE)) == '0);
  assign gnt_multi   = gnt_any && !gnt_one_hot;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (gnt[i]) begin
        gnt_idx = SIDW'(i);
      end
    end
  end

  assign out_vld  = (count != '0);
  assign out_data = mem_data[rd_ptr];
  assign out_src  = mem_src[rd_ptr];

  assign full = (count == FULL_LEVEL);
  assign pop  = out_vld && out_rdy;

  // A full buffer can still take a word when the head leaves in the same
  // cycle; otherwise the grant is lost and only ovf records it.
  assign push = gnt_one_hot && (!full || pop);
  assign drop = gnt_one_hot && full && !pop;

  assign count_next = count + CW'(push) - CW'(pop);

  // Entry storage needs no reset: nothing is visible until count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= data_in;
      mem_src[wr_ptr]  <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      blk    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      // Thresholding the post-update occupancy leaves BLK_MARGIN free slots
      // for grants the arbiter already has in flight.
      blk <= (count_next >= BLK_LEVEL);
      if (drop) begin
        ovf <= 1'b1;
      end
      if (gnt_multi) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_egress_queue.sv
// tb_egress_queue
//
// Scoreboard bench for egress_queue with NUM_REQS=2, WIDTH=8, OUT_DEPTH=4,
// BLK_MARGIN=2. Each driven cycle updates a reference queue of expected
// entries plus expected flag values; the DUT head is compared against the
// reference head every cycle and the counters/flags after every edge.

module tb_egress_queue;

  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  logic [7:0] data_in;
  logic       out_rdy;
  logic       out_vld;
  logic [7:0] out_data;
  logic [0:0] out_src;
  logic [2:0] count;
  logic       blk;
  logic       ovf;
  logic       err;

  typedef struct {
    logic [7:0] data;
    logic       src;
  } entry_t;

  entry_t sb[$];
  logic   exp_ovf;
  logic   exp_err;
  int     check_count;
  int     error_count;

  egress_queue #(
    .NUM_REQS  (2),
    .WIDTH     (8),
    .OUT_DEPTH (4),
    .BLK_MARGIN(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gnt     (gnt),
    .data_in (data_in),
    .out_rdy (out_rdy),
    .out_vld (out_vld),
    .out_data(out_data),
    .out_src (out_src),
    .count   (count),
    .blk     (blk),
    .ovf     (ovf),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks the head before the edge, updates
  // the reference model and checks occupancy and flags after the edge.
  task automatic applyStimulus(input logic [1:0] g, input logic [7:0] d, input logic r);
    logic exp_vld;
    logic do_pop;
    logic one_hot;
    logic is_full;
    entry_t e;
    gnt     = g;
    data_in = d;
    out_rdy = r;
    #1;
    exp_vld = (sb.size() != 0);
    checkOutput("out_vld", out_vld, exp_vld);
    if (exp_vld) begin
      checkOutput("out_data", out_data, sb[0].data);
      checkOutput("out_src", out_src, sb[0].src);
    end
    do_pop  = exp_vld && r;
    one_hot = (g == 2'b01) || (g == 2'b10);
    is_full = (sb.size() == 4);
    if (do_pop) void'(sb.pop_front());
    if (one_hot && (!is_full || do_pop)) begin
      e.data = d;
      e.src  = g[1];
      sb.push_back(e);
    end else if (one_hot) begin
      exp_ovf = 1'b1;
    end
    if (g == 2'b11) exp_err = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("count", count, sb.size());
    checkOutput("blk", blk, sb.size() >= 2);
    checkOutput("ovf", ovf, exp_ovf);
    checkOutput("err", err, exp_err);
  endtask

  // Asserts reset between clock edges and checks the outputs before any
  // further edge arrives.
  task automatic pulseReset();
    gnt     = 2'b00;
    out_rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_out_vld", out_vld, 1'b0);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_blk", blk, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    #1;
    rst = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    exp_ovf     = 1'b0;
    exp_err     = 1'b0;
    rst         = 1'b1;
    gnt         = 2'b00;
    data_in     = 8'h00;
    out_rdy     = 1'b0;

    // Reset asserted before the first clock edge ever occurs.
    #1;
    pulseReset();

    $display("[TB] single word, held head");
    applyStimulus(2'b10, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b0);

    $display("[TB] back-pressure threshold");
    applyStimulus(2'b01, 8'h01, 1'b0);
    applyStimulus(2'b10, 8'h02, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b0);

    $display("[TB] overflow");
    for (int i = 1; i <= 5; i++) applyStimulus(i[0] ? 2'b01 : 2'b10, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 8'h00, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b1);

    $display("[TB] full with simultaneous push and pop");
    pulseReset();
    for (int i = 1; i <= 4; i++) applyStimulus(i[0] ? 2'b10 : 2'b01, 8'(i), 1'b0);
    applyStimulus(2'b01, 8'h09, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 8'h00, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b0);

    $display("[TB] multi-hot grant and reset mid-operation");
    applyStimulus(2'b01, 8'h31, 1'b0);
    applyStimulus(2'b10, 8'h32, 1'b0);
    applyStimulus(2'b01, 8'h33, 1'b0);
    applyStimulus(2'b11, 8'h77, 1'b0);
    applyStimulus(2'b11, 8'h78, 1'b1);
    applyStimulus(2'b01, 8'h34, 1'b0);
    pulseReset();
    applyStimulus(2'b00, 8'h00, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      logic [1:0] g;
      g = 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 2));
      applyStimulus(g, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
